// File: rtl/defs.sv
// Shared decode definitions: RV32I opcode constants, immediate format enum and helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package defs;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_t;

   // Immediate layout selected by the major opcode; R-type and unknown carry no immediate.
   function automatic imm_fmt_t imm_fmt(input logic [6:0] opc);
      imm_fmt_t f;
      case (opc)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: f = IMM_I;
         OPC_STORE:                      f = IMM_S;
         OPC_BRANCH:                     f = IMM_B;
         OPC_LUI, OPC_AUIPC:             f = IMM_U;
         OPC_JAL:                        f = IMM_J;
         default:                        f = IMM_NONE;
      endcase
      return f;
   endfunction

   // True for the opcodes the executor understands; anything else becomes a bubble.
   function automatic logic opc_known(input logic [6:0] opc);
      logic k;
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
         OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: k = 1'b1;
         default:                               k = 1'b0;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: 2 combinational read ports, 1 write port, x0 reads as zero.
// Latency: reads 0 cycles; writes commit at the rising edge (same-cycle forward if DECODER_WB_BYPASS_EN).
// Backpressure: none; a write issued while rst is high is dropped.
module regfile
   import defs::*;
#(
   parameter int NREGS        = 32,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   input  logic [4:0]  rd_a_addr_i,
   output logic [31:0] rd_a_data_o,
   input  logic [4:0]  rd_b_addr_i,
   output logic [31:0] rd_b_data_o
);

   logic [31:0] regs_q [NREGS];
   logic        wr_ok;

   // Writes to x0 or beyond the implemented register count are discarded.
   assign wr_ok = wb_en_i && (wb_rd_i != 5'd0) && ({27'd0, wb_rd_i} < 32'(NREGS));

   // Register array update; reset optionally clears and always wins over a write.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (CLEAR_ON_RST != 0) begin
            for (int i = 0; i < NREGS; i++) begin
               regs_q[i] <= '0;
            end
         end
      end else if (wr_ok) begin
         regs_q[wb_rd_i] <= wb_data_i;
      end
   end

   // Read port A: x0 and unimplemented indices read zero.
   always_comb begin
      rd_a_data_o = '0;
      if (rd_a_addr_i != 5'd0 && {27'd0, rd_a_addr_i} < 32'(NREGS)) begin
         rd_a_data_o = regs_q[rd_a_addr_i];
`ifdef DECODER_WB_BYPASS_EN
         if (wr_ok && wb_rd_i == rd_a_addr_i) rd_a_data_o = wb_data_i;
`endif
      end
   end

   // Read port B: same rules as port A.
   always_comb begin
      rd_b_data_o = '0;
      if (rd_b_addr_i != 5'd0 && {27'd0, rd_b_addr_i} < 32'(NREGS)) begin
         rd_b_data_o = regs_q[rd_b_addr_i];
`ifdef DECODER_WB_BYPASS_EN
         if (wr_ok && wb_rd_i == rd_b_addr_i) rd_b_data_o = wb_data_i;
`endif
      end
   end

endmodule

// File: rtl/decoder.sv
// RV32I decode stage: field split, immediate generation, regfile read; optional DECODER_WB_BYPASS_EN forwarding.
// Latency: exactly 1 cycle from inputs to registered outputs.
// Backpressure: in_stall holds all outputs except source data, which is re-read from the held indices; in_flush turns the slot into a bubble.
module decoder
   import defs::*;
#(
   parameter int NREGS        = 32,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_addr,
   input  logic        in_noop,
   input  logic [31:0] in_instr,
   input  logic        in_stall,
   input  logic        in_flush,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic [31:0] out_addr,
   output logic        out_noop,
   output logic [6:0]  out_opcode,
   output logic [2:0]  out_funct3,
   output logic [6:0]  out_funct7,
   output logic [31:0] out_rs1_data,
   output logic [31:0] out_rs2_data,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rd,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2
);

   logic [31:0] addr_q, rs1_data_q, rs2_data_q, imm_q, imm_d;
   logic        noop_q, noop_d, load;
   logic [6:0]  opcode_q, funct7_q;
   logic [2:0]  funct3_q;
   logic [4:0]  rd_q, rs1_q, rs2_q, rs1_rd_addr, rs2_rd_addr;
   logic [31:0] rs1_rd_data, rs2_rd_data;

   // A flush always loads the new slot (as a bubble); only a plain stall holds.
   assign load   = in_flush || !in_stall;
   assign noop_d = in_flush || in_noop || !opc_known(in_instr[6:0]);

   // While holding, read through the held indices so late writebacks become visible.
   assign rs1_rd_addr = load ? in_instr[19:15] : rs1_q;
   assign rs2_rd_addr = load ? in_instr[24:20] : rs2_q;

   regfile #(
      .NREGS        (NREGS),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_regfile (
      .clk         (clk),
      .rst         (rst),
      .wb_en_i     (wb_en),
      .wb_rd_i     (wb_rd),
      .wb_data_i   (wb_data),
      .rd_a_addr_i (rs1_rd_addr),
      .rd_a_data_o (rs1_rd_data),
      .rd_b_addr_i (rs2_rd_addr),
      .rd_b_data_o (rs2_rd_data)
   );

   // Sign-extended immediate for the instruction's format.
   always_comb begin
      imm_d = '0;
      case (imm_fmt(in_instr[6:0]))
         IMM_I:   imm_d = {{20{in_instr[31]}}, in_instr[31:20]};
         IMM_S:   imm_d = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         IMM_B:   imm_d = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
         IMM_U:   imm_d = {in_instr[31:12], 12'h000};
         IMM_J:   imm_d = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
         default: imm_d = '0;
      endcase
   end

   // Pipeline register: reset > flush > stall > normal.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         noop_q     <= 1'b1;
         opcode_q   <= '0;
         funct3_q   <= '0;
         funct7_q   <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
      end else begin
         rs1_data_q <= rs1_rd_data;
         rs2_data_q <= rs2_rd_data;
         if (load) begin
            addr_q   <= in_addr;
            noop_q   <= noop_d;
            opcode_q <= in_instr[6:0];
            funct3_q <= in_instr[14:12];
            funct7_q <= in_instr[31:25];
            imm_q    <= imm_d;
            rd_q     <= in_instr[11:7];
            rs1_q    <= in_instr[19:15];
            rs2_q    <= in_instr[24:20];
         end
      end
   end

   assign out_addr     = addr_q;
   assign out_noop     = noop_q;
   assign out_opcode   = opcode_q;
   assign out_funct3   = funct3_q;
   assign out_funct7   = funct7_q;
   assign out_rs1_data = rs1_data_q;
   assign out_rs2_data = rs2_data_q;
   assign out_imm      = imm_q;
   assign out_rd       = rd_q;
   assign out_rs1      = rs1_q;
   assign out_rs2      = rs2_q;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: stimulus pushes expected outputs into a scoreboard queue.
// Latency: monitor pops one entry per cycle, 1 cycle after the stimulus edge.
// Backpressure: stall/flush sequences exercise the hold and re-read paths.
module tb_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_addr, in_instr, wb_data;
   logic        in_noop, in_stall, in_flush, wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] out_addr, out_rs1_data, out_rs2_data, out_imm;
   logic        out_noop;
   logic [6:0]  out_opcode, out_funct7;
   logic [2:0]  out_funct3;
   logic [4:0]  out_rd, out_rs1, out_rs2;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        noop;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   bit   stim_done = 1'b0;

`ifdef DECODER_WB_BYPASS_EN
   localparam logic [31:0] SAME_CYC_X1 = 32'd7;
`else
   localparam logic [31:0] SAME_CYC_X1 = 32'h100;
`endif

   always #5 clk = ~clk;

   decoder dut (
      .clk(clk), .rst(rst), .in_addr(in_addr), .in_noop(in_noop), .in_instr(in_instr),
      .in_stall(in_stall), .in_flush(in_flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_addr(out_addr), .out_noop(out_noop), .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_funct7(out_funct7), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2)
   );

   function automatic exp_t mk(input logic [31:0] addr, input logic [31:0] instr, input logic noop,
                               input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [31:0] imm);
      exp_t e;
      e.addr = addr; e.instr = instr; e.noop = noop;
      e.rs1d = rs1d; e.rs2d = rs2d; e.imm = imm;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] instr, input logic noop,
                        input logic stall, input logic flush);
      in_addr = addr; in_instr = instr; in_noop = noop; in_stall = stall; in_flush = flush;
   endtask

   task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
      wb_en = en; wb_rd = rd; wb_data = data;
   endtask

   task automatic step(input exp_t e);
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: every cycle the stage presents a slot; compare it against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("noop",     {31'd0, out_noop},   {31'd0, e.noop});
            chk("addr",     out_addr,            e.addr);
            chk("opcode",   {25'd0, out_opcode}, {25'd0, e.instr[6:0]});
            chk("funct3",   {29'd0, out_funct3}, {29'd0, e.instr[14:12]});
            chk("funct7",   {25'd0, out_funct7}, {25'd0, e.instr[31:25]});
            chk("rd",       {27'd0, out_rd},     {27'd0, e.instr[11:7]});
            chk("rs1",      {27'd0, out_rs1},    {27'd0, e.instr[19:15]});
            chk("rs2",      {27'd0, out_rs2},    {27'd0, e.instr[24:20]});
            chk("imm",      out_imm,             e.imm);
            chk("rs1_data", out_rs1_data,        e.rs1d);
            chk("rs2_data", out_rs2_data,        e.rs2d);
         end
      end
   end

   // Stimulus with hand-computed expectations.
   initial begin
      exp_t eg, eh;
      rst = 1'b1;
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      wb(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      step(mk(32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0));
      wb(1'b1, 5'd4, 32'h44);                          // dropped: rst is high
      step(mk(32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0));
      rst = 1'b0;
      wb(1'b1, 5'd1, 32'h100);
      drive(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(mk(32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0));
      wb(1'b1, 5'd2, 32'hDEAD);
      drive(32'h10, 32'hFFB00093, 1'b0, 1'b0, 1'b0);   // addi x1,x0,-5 (rs2 field = x27)
      step(mk(32'h10, 32'hFFB00093, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFB));
      wb(1'b0, 5'd0, 32'h0);
      drive(32'h14, 32'h0020A423, 1'b0, 1'b0, 1'b0);   // sw x2,8(x1)
      step(mk(32'h14, 32'h0020A423, 1'b0, 32'h100, 32'hDEAD, 32'h8));
      drive(32'h18, 32'hFE000EE3, 1'b0, 1'b0, 1'b0);   // beq x0,x0,-4
      step(mk(32'h18, 32'hFE000EE3, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFC));
      drive(32'h1C, 32'h001000EF, 1'b0, 1'b0, 1'b0);   // jal x1,2048 (rs2 field = x1)
      step(mk(32'h1C, 32'h001000EF, 1'b0, 32'h0, 32'h100, 32'h800));
      drive(32'h20, 32'h123452B7, 1'b0, 1'b0, 1'b0);   // lui x5,0x12345 (rs1 field x8, rs2 x3)
      step(mk(32'h20, 32'h123452B7, 1'b0, 32'h0, 32'h0, 32'h12345000));
      drive(32'h24, 32'h000081B3, 1'b0, 1'b0, 1'b0);   // add x3,x1,x0
      eg = mk(32'h24, 32'h000081B3, 1'b0, 32'h100, 32'h0, 32'h0);
      step(eg);
      // Stall 3 cycles; x1 written to 7 in the first stalled cycle.
      drive(32'h28, 32'hFFB00093, 1'b0, 1'b1, 1'b0);
      wb(1'b1, 5'd1, 32'd7);
      eh = eg; eh.rs1d = SAME_CYC_X1;
      step(eh);
      wb(1'b0, 5'd0, 32'h0);
      eh.rs1d = 32'd7;
      step(eh);
      step(eh);
      // Flush together with stall: slot loads as a bubble.
      drive(32'h30, 32'h0020A423, 1'b0, 1'b1, 1'b1);
      step(mk(32'h30, 32'h0020A423, 1'b1, 32'd7, 32'hDEAD, 32'h8));
      // Write to x0 is ignored.
      wb(1'b1, 5'd0, 32'h55);
      drive(32'h34, 32'h000001B3, 1'b0, 1'b0, 1'b0);
      step(mk(32'h34, 32'h000001B3, 1'b0, 32'h0, 32'h0, 32'h0));
      wb(1'b0, 5'd0, 32'h0);
      drive(32'h38, 32'h0000007F, 1'b0, 1'b0, 1'b0);   // unknown opcode
      step(mk(32'h38, 32'h0000007F, 1'b1, 32'h0, 32'h0, 32'h0));
      drive(32'h3C, 32'h000001B3, 1'b0, 1'b0, 1'b0);
      step(mk(32'h3C, 32'h000001B3, 1'b0, 32'h0, 32'h0, 32'h0));
      // Reset mid-stream, with a stall and a write that must both be ignored.
      rst = 1'b1;
      wb(1'b1, 5'd5, 32'h99);
      drive(32'h40, 32'h00208033, 1'b0, 1'b1, 1'b1);
      step(mk(32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0));
      rst = 1'b0;
      wb(1'b0, 5'd0, 32'h0);
      drive(32'h44, 32'h00208033, 1'b0, 1'b0, 1'b0);   // add x0,x1,x2 after reset
      step(mk(32'h44, 32'h00208033, 1'b0, 32'h0, 32'h0, 32'h0));
      drive(32'h48, 32'h00028033, 1'b0, 1'b0, 1'b0);   // reads x5: write during rst dropped
      step(mk(32'h48, 32'h00028033, 1'b0, 32'h0, 32'h0, 32'h0));
      drive(32'h4C, 32'hFFB00093, 1'b1, 1'b0, 1'b0);   // valid opcode but in_noop set
      step(mk(32'h4C, 32'hFFB00093, 1'b1, 32'h0, 32'h0, 32'hFFFFFFFB));
      drive(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      stim_done = 1'b1;
   end

   // Drain the scoreboard with a bounded wait, then report.
   initial begin
      wait (stim_done);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
